// File: rtl/note_voice_scheduler.sv
// rtl/note_voice_scheduler.sv - round-robin voice table that time-slices one tone divider
// Held keys own table entries; each valid entry sounds for SLICE_CYCLES per turn.
module note_voice_scheduler #(
  parameter int NUM_VOICES   = 4,
  parameter int SLICE_CYCLES = 2500000,
  parameter int CNT_W        = 20,
  localparam int IDX_W       = $clog2(NUM_VOICES),
  localparam int SLICE_W     = (SLICE_CYCLES > 1) ? $clog2(SLICE_CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_strobe,
  input  logic [7:0]            key_code,
  input  logic                  key_break,
  input  logic [CNT_W-1:0]      key_count,
  input  logic                  mb_mode,
  input  logic                  mb_play,
  input  logic [CNT_W-1:0]      mb_count,
  output logic [CNT_W-1:0]      tone_count,
  output logic                  voice_active,
  output logic [IDX_W-1:0]      voice_idx,
  output logic [NUM_VOICES-1:0] held_mask,
  output logic                  overflow
);

  typedef enum logic {IDLE, PLAY} state_t;

  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);

  logic [NUM_VOICES-1:0] valid;
  logic [7:0]            code_tab  [NUM_VOICES];
  logic [CNT_W-1:0]      count_tab [NUM_VOICES];

  state_t             state, state_n;
  logic [IDX_W-1:0]   cur, cur_n, base, hit_idx, free_idx, nxt_idx;
  logic [SLICE_W-1:0] slice, slice_n;
  logic               hit, free, nxt_found, wr_en;

  // Descending scans so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (valid[i] && code_tab[i] == key_code) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign wr_en = key_strobe && !key_break && !hit && free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (key_strobe && key_break && hit)
        valid[hit_idx] <= 1'b0;
      else if (wr_en)
        valid[free_idx] <= 1'b1;
      else if (key_strobe && !key_break && !hit)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      code_tab[free_idx]  <= key_code;
      count_tab[free_idx] <= key_count;
    end
  end

  // From IDLE the search starts just past the top entry so it lands on the lowest valid one.
  assign base = (state == IDLE) ? IDX_W'(NUM_VOICES - 1) : cur;

  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = cur;
    for (int k = NUM_VOICES; k >= 1; k--) begin
      if (valid[IDX_W'((int'(base) + k) % NUM_VOICES)]) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'((int'(base) + k) % NUM_VOICES);
      end
    end
  end

  always_comb begin
    state_n = state;
    cur_n   = cur;
    slice_n = slice;
    case (state)
      IDLE: begin
        if (nxt_found) begin
          state_n = PLAY;
          cur_n   = nxt_idx;
          slice_n = '0;
        end
      end
      PLAY: begin
        if (!valid[cur] || slice == SLICE_LAST) begin
          slice_n = '0;
          if (nxt_found) begin
            cur_n = nxt_idx;
          end else begin
            state_n = IDLE;
            cur_n   = '0;
          end
        end else begin
          slice_n = slice + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cur          <= '0;
      slice        <= '0;
      tone_count   <= '0;
      voice_active <= 1'b0;
    end else begin
      state        <= state_n;
      cur          <= cur_n;
      slice        <= slice_n;
      voice_active <= !mb_mode && (state_n == PLAY);
      if (mb_mode)
        tone_count <= mb_play ? mb_count : '0;
      else
        tone_count <= (state_n == PLAY) ? count_tab[cur_n] : '0;
    end
  end

  assign voice_idx = cur;
  assign held_mask = valid;

endmodule
